lut_multiplier_32b_seq: RTL and testbench

// - Sequential 32x32 -> 64-bit unsigned multiplier; the control/accumulate stage directly upstream of lut_multiplier_4b_cond.
// - Latches both operands on start, feeds one 4-bit digit of operand B per cycle to a single lut_multiplier_4b_cond.
// - Consumes that block's 64-bit partial product and accumulates it, shifted by 4*digit index, into the final result.
// - Pulses done when the product is complete.

---
 rtl/lut_mult_pkg.sv | 29 ++
 rtl/lut_multiplier_4b_cond.sv | 60 ++++++
 rtl/lut_multiplier_32b_seq.sv | 102 ++++++++++
 tb/tb_lut_multiplier_32b_seq.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_mult_pkg.sv
// -----------------------------------------------------------------------------
// lut_mult_pkg
// Shared definitions for the sequential 32x32 LUT multiplier and its 4-bit
// digit multiplier: FSM state encoding, datapath widths and a helper that
// tells whether the multiplier digits above the current one are all zero.
// -----------------------------------------------------------------------------
package lut_mult_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 8;
  localparam int OPERAND_W  = 32;
  localparam int RESULT_W   = 64;
  localparam int IDX_W      = 3;                    // log2(NUM_DIGITS)
  localparam int PP_W       = OPERAND_W + DIGIT_W;  // significant partial-product bits

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // True when every digit of b above digit position idx is zero. At idx = 7
  // the shift moves all bits out, so the last digit always reports true.
  function automatic logic upper_digits_zero(input logic [OPERAND_W-1:0] b,
                                             input logic [IDX_W-1:0]     idx);
    return (b >> ((int'(idx) + 1) * DIGIT_W)) == '0;
  endfunction

endpackage : lut_mult_pkg

// File: rtl/lut_multiplier_4b_cond.sv
// -----------------------------------------------------------------------------
// lut_multiplier_4b_cond
// Combinational 32-bit x 4-bit unsigned digit multiplier. The product is
// selected from a table of the sixteen multiples of the multiplicand, each
// built from at most three shifted terms. The output is forced to zero while
// resetn_4b is low.
//
// Ports
//   resetn_4b        in   1   active-low enable/reset; 0 forces product to 0
//   multiplicand_4b  in  32   operand A
//   digit_4b         in   4   one digit of operand B
//   product_4b       out 64   A * digit, zero-extended (36 significant bits)
// -----------------------------------------------------------------------------
module lut_multiplier_4b_cond
  import lut_mult_pkg::*;
(
  input  logic                 resetn_4b,
  input  logic [OPERAND_W-1:0] multiplicand_4b,
  input  logic [DIGIT_W-1:0]   digit_4b,
  output logic [RESULT_W-1:0]  product_4b
);

  logic [PP_W-1:0] m1, m2, m4, m8, m16;
  logic [PP_W-1:0] lut_val;

  // 16*A < 2^36, so every table entry fits PP_W bits without overflow.
  assign m1  = {{(PP_W-OPERAND_W){1'b0}}, multiplicand_4b};
  assign m2  = m1 << 1;
  assign m4  = m1 << 2;
  assign m8  = m1 << 3;
  assign m16 = m1 << 4;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch cannot be inferred.
    lut_val = '0;
    unique case (digit_4b)
      4'd0:  lut_val = '0;
      4'd1:  lut_val = m1;
      4'd2:  lut_val = m2;
      4'd3:  lut_val = m2 + m1;
      4'd4:  lut_val = m4;
      4'd5:  lut_val = m4 + m1;
      4'd6:  lut_val = m4 + m2;
      4'd7:  lut_val = m8 - m1;
      4'd8:  lut_val = m8;
      4'd9:  lut_val = m8 + m1;
      4'd10: lut_val = m8 + m2;
      4'd11: lut_val = m8 + m2 + m1;
      4'd12: lut_val = m8 + m4;
      4'd13: lut_val = m8 + m4 + m1;
      4'd14: lut_val = m16 - m2;
      4'd15: lut_val = m16 - m1;
      default: lut_val = '0;
    endcase
  end

  assign product_4b = resetn_4b ? {{(RESULT_W-PP_W){1'b0}}, lut_val} : '0;

endmodule : lut_multiplier_4b_cond

// File: rtl/lut_multiplier_32b_seq.sv
// -----------------------------------------------------------------------------
// lut_multiplier_32b_seq
// Sequential 32x32 -> 64-bit unsigned multiplier. Operands are latched on an
// accepted start; one 4-bit digit of B per cycle is multiplied by A in a
// single lut_multiplier_4b_cond and the partial product, shifted by
// 4*digit index, is accumulated. The finished sum is copied into result_32b
// on the transition into DONE, so a partial sum is never visible.
// With SKIP_ZERO=1 the run stops early once all higher digits of B are zero.
//
// Ports
//   clk_32b              in   1   clock, rising edge
//   reset_32b            in   1   asynchronous, active-high reset
//   start_32b            in   1   start request, honoured in IDLE or DONE
//   source_number_32b_0  in  32   operand A (multiplicand)
//   source_number_32b_1  in  32   operand B (multiplier)
//   busy_32b             out  1   high while digits are being processed
//   done_32b             out  1   one-cycle pulse when result_32b is new
//   result_32b           out 64   A*B, held until the next operation completes
// -----------------------------------------------------------------------------
module lut_multiplier_32b_seq
  import lut_mult_pkg::*;
#(
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic                 clk_32b,
  input  logic                 reset_32b,
  input  logic                 start_32b,
  input  logic [OPERAND_W-1:0] source_number_32b_0,
  input  logic [OPERAND_W-1:0] source_number_32b_1,
  output logic                 busy_32b,
  output logic                 done_32b,
  output logic [RESULT_W-1:0]  result_32b
);

  state_t               state, state_next;
  logic [OPERAND_W-1:0] a_reg, b_reg;
  logic [RESULT_W-1:0]  acc, result_reg;
  logic [IDX_W-1:0]     idx;

  logic [DIGIT_W-1:0]   digit;
  logic [RESULT_W-1:0]  pp, acc_sum;
  logic                 last_digit;
  logic                 accept;
  logic                 resetn_4b;

  assign digit     = b_reg[idx*DIGIT_W +: DIGIT_W];
  assign resetn_4b = ~reset_32b;

  lut_multiplier_4b_cond u_digit_mult (
    .resetn_4b       (resetn_4b),
    .multiplicand_4b (a_reg),
    .digit_4b        (digit),
    .product_4b      (pp)
  );

  // pp has at most 36 significant bits and the largest shift is 28, so the
  // shifted term and the running sum both stay within 64 bits.
  assign acc_sum    = acc + (pp << (idx * DIGIT_W));
  assign last_digit = (idx == IDX_W'(NUM_DIGITS - 1)) ||
                      (SKIP_ZERO && upper_digits_zero(b_reg, idx));
  assign accept     = start_32b && ((state == IDLE) || (state == DONE));

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start_32b) state_next = CALC;
      CALC:    if (last_digit) state_next = DONE;
      DONE:    state_next = start_32b ? CALC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and update order inside the block is irrelevant.
  always_ff @(posedge clk_32b or posedge reset_32b) begin
    if (reset_32b) begin
      state      <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      acc        <= '0;
      idx        <= '0;
      result_reg <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        a_reg <= source_number_32b_0;
        b_reg <= source_number_32b_1;
        acc   <= '0;
        idx   <= '0;
      end else if (state == CALC) begin
        acc <= acc_sum;
        idx <= idx + 1'b1;
        if (last_digit) result_reg <= acc_sum;
      end
    end
  end

  assign busy_32b   = (state == CALC);
  assign done_32b   = (state == DONE);
  assign result_32b = result_reg;

endmodule : lut_multiplier_32b_seq

// File: tb/tb_lut_multiplier_32b_seq.sv
// -----------------------------------------------------------------------------
// tb_lut_multiplier_32b_seq
// Two instances share clock and reset: u_dut0 (SKIP_ZERO=0) and
// u_dut1 (SKIP_ZERO=1). Expected products come from 64-bit arithmetic and
// expected latencies from the position of B's highest nonzero digit.
// -----------------------------------------------------------------------------
module tb_lut_multiplier_32b_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        busy0, done0, busy1, done1;
  logic [63:0] res0, res1;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lut_multiplier_32b_seq #(.SKIP_ZERO(1'b0)) u_dut0 (
    .clk_32b             (clk),
    .reset_32b           (rst),
    .start_32b           (start0),
    .source_number_32b_0 (a0),
    .source_number_32b_1 (b0),
    .busy_32b            (busy0),
    .done_32b            (done0),
    .result_32b          (res0)
  );

  lut_multiplier_32b_seq #(.SKIP_ZERO(1'b1)) u_dut1 (
    .clk_32b             (clk),
    .reset_32b           (rst),
    .start_32b           (start1),
    .source_number_32b_0 (a1),
    .source_number_32b_1 (b1),
    .busy_32b            (busy1),
    .done_32b            (done1),
    .result_32b          (res1)
  );

  // Reference model: product and cycles from accepted start to done pulse.
  function automatic logic [63:0] model_product(input logic [31:0] a, input logic [31:0] b);
    return 64'(a) * 64'(b);
  endfunction

  function automatic int model_latency(input bit sz, input logic [31:0] b);
    int hi;
    if (!sz) return 9;
    hi = 0;
    for (int d = 0; d < 8; d++)
      if (((b >> (4 * d)) & 32'hF) != 0) hi = d;
    return hi + 2;
  endfunction

  // Called at a negedge. Issues one start, scrambles the operand ports after
  // acceptance, and returns at the negedge on which done is seen (bounded).
  task automatic do_op(input bit sz, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int busy_cnt,
                       output logic [63:0] res, output logic [63:0] res_early);
    if (sz) begin start1 = 1'b1; a1 = a; b1 = b; end
    else    begin start0 = 1'b1; a0 = a; b0 = b; end
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    if (sz) begin a1 = $urandom; b1 = $urandom; end
    else    begin a0 = $urandom; b0 = $urandom; end
    lat       = 0;
    busy_cnt  = 0;
    res_early = sz ? res1 : res0;
    repeat (20) begin
      lat++;
      if (sz ? done1 : done0) break;
      if (sz ? busy1 : busy0) busy_cnt++;
      @(negedge clk);
    end
    res = sz ? res1 : res0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL reset_busy0: got %b expected 0", busy0); end
    vectors++; if (done0 !== 1'b0) begin miscompares++; $display("FAIL reset_done0: got %b expected 0", done0); end
    vectors++; if (res0 !== 64'd0) begin miscompares++; $display("FAIL reset_res0: got %h expected 0", res0); end
    vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL reset_busy1: got %b expected 0", busy1); end
    vectors++; if (done1 !== 1'b0) begin miscompares++; $display("FAIL reset_done1: got %b expected 0", done1); end
    vectors++; if (res1 !== 64'd0) begin miscompares++; $display("FAIL reset_res1: got %h expected 0", res1); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, bc;
    logic [63:0] r, re;
    do_op(1'b0, 32'd7, 32'd6, lat, bc, r, re);
    vectors++; if (lat !== 9) begin miscompares++; $display("FAIL basic_latency: got %0d expected 9", lat); end
    vectors++; if (bc !== 8) begin miscompares++; $display("FAIL basic_busy_cycles: got %0d expected 8", bc); end
    vectors++; if (r !== 64'd42) begin miscompares++; $display("FAIL basic_result: got %h expected %h", r, 64'd42); end
    @(negedge clk);
    vectors++; if (done0 !== 1'b0) begin miscompares++; $display("FAIL basic_done_pulse_width: got %b expected 0", done0); end
    vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL basic_back_to_idle: got %b expected 0", busy0); end
    vectors++; if (res0 !== 64'd42) begin miscompares++; $display("FAIL basic_result_held: got %h expected %h", res0, 64'd42); end
  endtask

  task automatic test_max_and_order();
    int lat, bc;
    logic [63:0] r, re;
    do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc, r, re);
    vectors++; if (r !== 64'hFFFF_FFFE_0000_0001) begin miscompares++; $display("FAIL max_result: got %h expected %h", r, 64'hFFFF_FFFE_0000_0001); end
    vectors++; if (re !== 64'd42) begin miscompares++; $display("FAIL max_no_partial_exposed: got %h expected %h", re, 64'd42); end
    @(negedge clk);
    do_op(1'b0, 32'h1, 32'h8765_4321, lat, bc, r, re);
    vectors++; if (r !== 64'h8765_4321) begin miscompares++; $display("FAIL digit_order_result: got %h expected %h", r, 64'h8765_4321); end
    @(negedge clk);
    do_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc, r, re);
    vectors++; if (r !== 64'hFFFF_FFFE_0000_0001) begin miscompares++; $display("FAIL max_skip_result: got %h expected %h", r, 64'hFFFF_FFFE_0000_0001); end
    vectors++; if (lat !== 9) begin miscompares++; $display("FAIL max_skip_latency: got %0d expected 9", lat); end
    @(negedge clk);
  endtask

  task automatic test_ignored_start();
    int lat, busy_seen, done_seen;
    start0 = 1'b1; a0 = 32'd7; b0 = 32'd6;
    @(posedge clk);
    @(negedge clk);
    a0 = 32'd5; b0 = 32'd5;   // start held high into CALC with new operands
    lat = 0;
    repeat (20) begin
      lat++;
      if (lat == 5) start0 = 1'b0;
      if (done0) break;
      @(negedge clk);
    end
    vectors++; if (lat !== 9) begin miscompares++; $display("FAIL ignored_start_latency: got %0d expected 9", lat); end
    vectors++; if (res0 !== 64'd42) begin miscompares++; $display("FAIL ignored_start_result: got %h expected %h", res0, 64'd42); end
    busy_seen = 0; done_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy0) busy_seen++;
      if (done0) done_seen++;
    end
    vectors++; if (busy_seen !== 0) begin miscompares++; $display("FAIL ignored_start_no_second_op: got %0d busy cycles expected 0", busy_seen); end
    vectors++; if (done_seen !== 0) begin miscompares++; $display("FAIL ignored_start_no_second_done: got %0d expected 0", done_seen); end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    logic [63:0] r, re, first;
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    first = model_product(a, b);
    do_op(1'b0, a, b, lat, bc, r, re);
    vectors++; if (r !== first) begin miscompares++; $display("FAIL b2b_first_result: got %h expected %h", r, first); end
    // Still at the DONE negedge: the next start is accepted from DONE.
    do_op(1'b0, 32'd3, 32'd4, lat, bc, r, re);
    vectors++; if (re !== first) begin miscompares++; $display("FAIL b2b_result_held_in_calc: got %h expected %h", re, first); end
    vectors++; if (lat !== 9) begin miscompares++; $display("FAIL b2b_latency: got %0d expected 9", lat); end
    vectors++; if (r !== 64'd12) begin miscompares++; $display("FAIL b2b_second_result: got %h expected %h", r, 64'd12); end
    @(negedge clk);
  endtask

  task automatic test_skip_zero();
    int lat, bc;
    logic [63:0] r, re;
    logic [31:0] a;
    do_op(1'b1, 32'd10, 32'h0000_0003, lat, bc, r, re);
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL skip_small_latency: got %0d expected 2", lat); end
    vectors++; if (r !== 64'd30) begin miscompares++; $display("FAIL skip_small_result: got %h expected %h", r, 64'd30); end
    @(negedge clk);
    a = $urandom;
    do_op(1'b1, a, 32'h0, lat, bc, r, re);
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL skip_zero_b_latency: got %0d expected 2", lat); end
    vectors++; if (r !== 64'd0) begin miscompares++; $display("FAIL skip_zero_b_result: got %h expected 0", r); end
    @(negedge clk);
    a = $urandom;
    do_op(1'b1, a, 32'h0001_0000, lat, bc, r, re);
    vectors++; if (lat !== 6) begin miscompares++; $display("FAIL skip_digit4_latency: got %0d expected 6", lat); end
    vectors++; if (r !== model_product(a, 32'h0001_0000)) begin miscompares++; $display("FAIL skip_digit4_result: got %h expected %h", r, model_product(a, 32'h0001_0000)); end
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat, bc, exp_lat, sh;
    bit sz;
    logic [63:0] r, re, exp;
    logic [31:0] a, b, raw;
    for (int i = 0; i < 24; i++) begin
      sz  = i[0];
      a   = $urandom;
      raw = $urandom;
      sh  = 4 * $urandom_range(0, 8);
      b   = (sh >= 32) ? 32'd0 : (raw >> sh);
      exp     = model_product(a, b);
      exp_lat = model_latency(sz, b);
      do_op(sz, a, b, lat, bc, r, re);
      vectors++; if (r !== exp) begin miscompares++; $display("FAIL random_result[%0d] sz=%0d a=%h b=%h: got %h expected %h", i, sz, a, b, r, exp); end
      vectors++; if (lat !== exp_lat) begin miscompares++; $display("FAIL random_latency[%0d] sz=%0d b=%h: got %0d expected %0d", i, sz, b, lat, exp_lat); end
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  task automatic test_mid_reset();
    int lat, bc, done_seen, busy_seen;
    logic [63:0] r, re;
    logic [31:0] a, b;
    do_op(1'b1, 32'd10, 32'd3, lat, bc, r, re);
    vectors++; if (res1 !== 64'd30) begin miscompares++; $display("FAIL midreset_setup_res1: got %h expected %h", res1, 64'd30); end
    @(negedge clk);
    start0 = 1'b1; a0 = 32'hDEAD_BEEF; b0 = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    repeat (4) @(negedge clk);   // CALC at idx 4
    #2 rst = 1'b1;
    #1;
    vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL midreset_busy_async: got %b expected 0", busy0); end
    vectors++; if (done0 !== 1'b0) begin miscompares++; $display("FAIL midreset_done_async: got %b expected 0", done0); end
    vectors++; if (res0 !== 64'd0) begin miscompares++; $display("FAIL midreset_res0_async: got %h expected 0", res0); end
    vectors++; if (res1 !== 64'd0) begin miscompares++; $display("FAIL midreset_res1_async: got %h expected 0", res1); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0; busy_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done0) done_seen++;
      if (busy0) busy_seen++;
    end
    vectors++; if (done_seen !== 0) begin miscompares++; $display("FAIL midreset_no_done: got %0d pulses expected 0", done_seen); end
    vectors++; if (busy_seen !== 0) begin miscompares++; $display("FAIL midreset_stays_idle: got %0d busy cycles expected 0", busy_seen); end
    a = $urandom; b = $urandom;
    do_op(1'b0, a, b, lat, bc, r, re);
    vectors++; if (r !== model_product(a, b)) begin miscompares++; $display("FAIL midreset_recovery_result: got %h expected %h", r, model_product(a, b)); end
    vectors++; if (lat !== 9) begin miscompares++; $display("FAIL midreset_recovery_latency: got %0d expected 9", lat); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_and_order();
    test_ignored_start();
    test_back_to_back();
    test_skip_zero();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_lut_multiplier_32b_seq
